// File: rtl/ecp5_ff_pipe.sv
// ecp5_ff_pipe: elastic WIDTH x DEPTH register pipeline with ECP5 slice-FF style GSR/LSR/CE controls.
// Define ECP5_FF_PIPE_OCC_EN to add the registered occupancy and full outputs.
module ecp5_ff_pipe #(
  parameter int    WIDTH  = 8,
  parameter int    DEPTH  = 3,
  parameter string REGSET = "RESET",
  parameter string SRMODE = "LSR_OVER_CE",
  parameter string GSR    = "ENABLED"
) (
  input  logic             CLK,
  input  logic             GSRN,
  input  logic             CE,
  input  logic             LSR,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef ECP5_FF_PIPE_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       full
`endif
);

  localparam logic [WIDTH-1:0] SR_VAL    = (REGSET == "SET") ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  localparam bit               LSR_ASYNC = (SRMODE == "ASYNC");
  localparam bit               GSR_EN    = (GSR == "ENABLED");

  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH:0]   r;

  // r[i]: stage i may load this cycle (empty, or its contents move on).
  always_comb begin
    r        = '0;
    r[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      r[i] = ~v_q[i] | r[i+1];
    end
  end

  // Bubbles only clear the valid bit; data registers keep their old word.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (r[0]) begin
      v_d[0] = in_valid;
      if (in_valid) d_d[0] = in_data;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (r[i]) begin
        v_d[i] = v_q[i-1];
        if (v_q[i-1]) d_d[i] = d_q[i-1];
      end
    end
  end

  assign in_ready  = CE & r[0] & GSRN & ~LSR;
  assign out_valid = CE & v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];

`ifdef ECP5_FF_PIPE_OCC_EN
  localparam int OW = $clog2(DEPTH + 1);
  logic [OW-1:0] occ_q, occ_d;

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + OW'(v_d[i]);
    end
  end

  assign occupancy = occ_q;
  assign full      = (occ_q == OW'(DEPTH));
`endif

  generate
    if (LSR_ASYNC) begin : g_v_async
      always_ff @(posedge CLK or negedge GSRN or posedge LSR) begin
        if (!GSRN) begin
          v_q <= '0;
`ifdef ECP5_FF_PIPE_OCC_EN
          occ_q <= '0;
`endif
        end else if (LSR) begin
          v_q <= '0;
`ifdef ECP5_FF_PIPE_OCC_EN
          occ_q <= '0;
`endif
        end else if (CE) begin
          v_q <= v_d;
`ifdef ECP5_FF_PIPE_OCC_EN
          occ_q <= occ_d;
`endif
        end
      end
    end else begin : g_v_sync
      always_ff @(posedge CLK or negedge GSRN) begin
        if (!GSRN) begin
          v_q <= '0;
`ifdef ECP5_FF_PIPE_OCC_EN
          occ_q <= '0;
`endif
        end else if (LSR) begin
          v_q <= '0;
`ifdef ECP5_FF_PIPE_OCC_EN
          occ_q <= '0;
`endif
        end else if (CE) begin
          v_q <= v_d;
`ifdef ECP5_FF_PIPE_OCC_EN
          occ_q <= occ_d;
`endif
        end
      end
    end

    // With GSR disabled the data registers ignore GSRN entirely; only loads are blocked.
    if (GSR_EN && LSR_ASYNC) begin : g_d_gsr_async
      always_ff @(posedge CLK or negedge GSRN or posedge LSR) begin
        if (!GSRN)    d_q <= '{default: SR_VAL};
        else if (LSR) d_q <= '{default: SR_VAL};
        else if (CE)  d_q <= d_d;
      end
    end else if (GSR_EN) begin : g_d_gsr_sync
      always_ff @(posedge CLK or negedge GSRN) begin
        if (!GSRN)    d_q <= '{default: SR_VAL};
        else if (LSR) d_q <= '{default: SR_VAL};
        else if (CE)  d_q <= d_d;
      end
    end else if (LSR_ASYNC) begin : g_d_nogsr_async
      always_ff @(posedge CLK or posedge LSR) begin
        if (LSR)             d_q <= '{default: SR_VAL};
        else if (CE && GSRN) d_q <= d_d;
      end
    end else begin : g_d_nogsr_sync
      always_ff @(posedge CLK) begin
        if (LSR)             d_q <= '{default: SR_VAL};
        else if (CE && GSRN) d_q <= d_d;
      end
    end
  endgenerate

endmodule

// File: tb/tb_ecp5_ff_pipe.sv
// Scoreboard bench for ecp5_ff_pipe: DUT A (SET, GSR on, sync LSR) random + directed, DUT B (RESET, GSR off, async LSR) directed.
module tb_ecp5_ff_pipe;
  localparam int W = 8;
  localparam int D = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         a_gsrn, a_ce, a_lsr, a_iv, a_ir, a_ov, a_or;
  logic [W-1:0] a_id, a_od;
  logic         b_gsrn, b_ce, b_lsr, b_iv, b_ir, b_ov, b_or;
  logic [W-1:0] b_id, b_od;
`ifdef ECP5_FF_PIPE_OCC_EN
  logic [1:0]   a_occ, b_occ;
  logic         a_full, b_full;
`endif

  ecp5_ff_pipe #(.WIDTH(W), .DEPTH(D), .REGSET("SET"), .SRMODE("LSR_OVER_CE"), .GSR("ENABLED")) u_a (
    .CLK(clk), .GSRN(a_gsrn), .CE(a_ce), .LSR(a_lsr),
    .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od)
`ifdef ECP5_FF_PIPE_OCC_EN
    , .occupancy(a_occ), .full(a_full)
`endif
  );

  ecp5_ff_pipe #(.WIDTH(W), .DEPTH(D), .REGSET("RESET"), .SRMODE("ASYNC"), .GSR("DISABLED")) u_b (
    .CLK(clk), .GSRN(b_gsrn), .CE(b_ce), .LSR(b_lsr),
    .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od)
`ifdef ECP5_FF_PIPE_OCC_EN
    , .occupancy(b_occ), .full(b_full)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the pipeline is a queue of at most D words; it can accept
  // whenever fewer than D are held or the downstream takes one this cycle.
  always begin
    int n;
    @(negedge clk);
    #1;
    n = exp_q.size();
    if (!a_gsrn) begin
      chk("rst_in_ready", 32'(a_ir), 32'd0);
      chk("rst_out_valid", 32'(a_ov), 32'd0);
      exp_q.delete();
    end else if (a_lsr) begin
      chk("lsr_in_ready", 32'(a_ir), 32'd0);
      exp_q.delete();
    end else begin
      chk("in_ready", 32'(a_ir), 32'(a_ce && (n < D || a_or)));
      chk("out_valid_legal", 32'(a_ov && !(a_ce && n > 0)), 32'd0);
`ifdef ECP5_FF_PIPE_OCC_EN
      chk("occupancy", 32'(a_occ), 32'(n));
      chk("full", 32'(a_full), 32'(n == D));
`endif
      if (a_ov && a_or) begin
        if (n == 0) chk("out_with_nothing_queued", 32'(n), 32'd1);
        else        chk("out_data", 32'(a_od), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic cyc(input logic c, input logic iv, input logic [W-1:0] dat, input logic ordy, input logic l);
    @(negedge clk);
    a_ce = c; a_iv = iv; a_id = dat; a_or = ordy; a_lsr = l;
    #2;
    if (a_iv && a_ir) exp_q.push_back(a_id);
  endtask

  task automatic cyc_b(input logic c, input logic iv, input logic [W-1:0] dat, input logic ordy);
    @(negedge clk);
    b_ce = c; b_iv = iv; b_id = dat; b_or = ordy;
    #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    a_gsrn = 1'b0; a_ce = 1'b1; a_lsr = 1'b0; a_iv = 1'b1; a_id = 8'h77; a_or = 1'b1;
    b_gsrn = 1'b0; b_ce = 1'b1; b_lsr = 1'b0; b_iv = 1'b0; b_id = '0;    b_or = 1'b1;

    // Reset values
    cyc(1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
    chk("rst_out_data", 32'(a_od), 32'hFF);
    chk("rst_out_valid_d", 32'(a_ov), 32'd0);
    chk("rst_in_ready_d", 32'(a_ir), 32'd0);
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    a_gsrn = 1'b1;
    b_gsrn = 1'b1;
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("rel_in_ready", 32'(a_ir), 32'd1);

    // Latency and throughput
    for (int k = 0; k < 9; k++) begin
      cyc(1'b1, 1'(k < 5), W'(k + 1), 1'b1, 1'b0);
      chk($sformatf("lat_out_valid_%0d", k), 32'(a_ov), 32'(k >= 3 && k <= 7));
      if (k >= 3 && k <= 7) chk($sformatf("lat_out_data_%0d", k), 32'(a_od), 32'(k - 2));
    end

    // Backpressure
    cyc(1'b1, 1'b1, 8'hA0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'hA1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'hA2, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'hA3, 1'b0, 1'b0);
    chk("bp_full_in_ready", 32'(a_ir), 32'd0);
    chk("bp_full_out_data", 32'(a_od), 32'hA0);
    cyc(1'b1, 1'b1, 8'hA3, 1'b1, 1'b0);
    chk("bp_release_in_ready", 32'(a_ir), 32'd1);
    repeat (5) cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // Bubble collapse
    cyc(1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("bub_out_valid", 32'(a_ov), 32'd1);
    chk("bub_out_data", 32'(a_od), 32'h11);
    chk("bub_in_ready", 32'(a_ir), 32'd1);
    chk("bub_held", 32'(exp_q.size()), 32'd2);

    // Synchronous LSR beats CE=0
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("lsr_ce0_in_ready", 32'(a_ir), 32'd0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("lsr_out_data", 32'(a_od), 32'hFF);
    chk("lsr_out_valid", 32'(a_ov), 32'd0);
    chk("lsr_in_ready_after", 32'(a_ir), 32'd1);

    // Random traffic
    repeat (1500) begin
      cyc(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 9) < 7), W'($urandom),
          1'($urandom_range(0, 9) < 6), 1'b0);
    end
    t = 0;
    while (exp_q.size() > 0 && t < 20) begin
      cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      t++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    // DUT B: GSR disabled keeps data through GSRN
    cyc_b(1'b1, 1'b1, 8'h5A, 1'b0);
    repeat (3) cyc_b(1'b1, 1'b0, 8'h00, 1'b0);
    chk("b_load_out_valid", 32'(b_ov), 32'd1);
    chk("b_load_out_data", 32'(b_od), 32'h5A);
    @(negedge clk);
    b_gsrn = 1'b0;
    #2;
    chk("b_gsr_out_valid", 32'(b_ov), 32'd0);
    chk("b_gsr_out_data", 32'(b_od), 32'h5A);
    chk("b_gsr_in_ready", 32'(b_ir), 32'd0);
    @(negedge clk);
    #2;
    chk("b_gsr_hold_data", 32'(b_od), 32'h5A);
    b_gsrn = 1'b1;
    cyc_b(1'b1, 1'b0, 8'h00, 1'b1);
    chk("b_gsr_rel_out_valid", 32'(b_ov), 32'd0);
    chk("b_gsr_rel_in_ready", 32'(b_ir), 32'd1);

    // DUT B: asynchronous LSR clears before the next edge
    cyc_b(1'b1, 1'b1, 8'h33, 1'b0);
    cyc_b(1'b1, 1'b1, 8'h44, 1'b0);
    cyc_b(1'b1, 1'b0, 8'h00, 1'b0);
    cyc_b(1'b1, 1'b0, 8'h00, 1'b0);
    chk("b_pre_lsr_out_valid", 32'(b_ov), 32'd1);
    chk("b_pre_lsr_out_data", 32'(b_od), 32'h33);
    @(negedge clk);
    b_lsr = 1'b1;
    #2;
    chk("b_alsr_out_data", 32'(b_od), 32'h00);
    chk("b_alsr_out_valid", 32'(b_ov), 32'd0);
    chk("b_alsr_in_ready", 32'(b_ir), 32'd0);
    @(negedge clk);
    #2;
    chk("b_alsr_hold_valid", 32'(b_ov), 32'd0);
    chk("b_alsr_hold_data", 32'(b_od), 32'h00);
`ifdef ECP5_FF_PIPE_OCC_EN
    chk("b_alsr_occ", 32'(b_occ), 32'd0);
`endif
    b_lsr = 1'b0;
    cyc_b(1'b1, 1'b0, 8'h00, 1'b1);
    chk("b_alsr_rel_in_ready", 32'(b_ir), 32'd1);
    chk("b_alsr_rel_out_valid", 32'(b_ov), 32'd0);
    cyc_b(1'b1, 1'b1, 8'h66, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      cyc_b(1'b1, 1'b0, 8'h00, 1'b1);
      chk($sformatf("b_lat_out_valid_%0d", k), 32'(b_ov), 32'(k == 3));
    end
    chk("b_lat_out_data", 32'(b_od), 32'h66);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
